// File: rtl/instr_align.sv
// Instruction-align stage: buffers fetched halfwords and reassembles RVC and
// 32-bit instructions (including ones straddling a fetch word) for decode.
// Optional feature macro: INSTR_ALIGN_RVC_EN (compressed support). When it is
// undefined every instruction is 32-bit and a pc[1]=1 fetch becomes a
// misalignment exception entry.
module instr_align #(
  parameter int unsigned PC_W         = 32,
  parameter int unsigned EXC_W        = 4,
  parameter int unsigned Q_DEPTH      = 4,
  parameter int unsigned EXC_MISALIGN = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_stall,
  input  logic             i_valid,
  input  logic [PC_W-1:0]  i_pc,
  input  logic [15:0]      i_data0,
  input  logic [15:0]      i_data1,
  input  logic             i_except_valid,
  input  logic [EXC_W-1:0] i_except_code,
  output logic             o_stall,
  output logic             o_valid,
  output logic [PC_W-1:0]  o_pc,
  output logic [31:0]      o_instr,
  output logic             o_compressed,
  output logic             o_except_valid,
  output logic [EXC_W-1:0] o_except_code
);

  localparam int unsigned PTR_W = $clog2(Q_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

`ifdef INSTR_ALIGN_RVC_EN
  localparam bit RVC_EN = 1'b1;
`else
  localparam bit RVC_EN = 1'b0;
`endif

  // halfword queue storage
  logic [15:0]      half_q [Q_DEPTH];
  logic [PC_W-1:0]  epc_q  [Q_DEPTH];
  logic             exv_q  [Q_DEPTH];
  logic [EXC_W-1:0] ecode_q[Q_DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, nxt;
  logic [CNT_W-1:0] count_q, count_d;

  // push side
  logic             push_en;
  logic [1:0]       push_n;
  logic [15:0]      w0_half;
  logic             w0_exv;
  logic [EXC_W-1:0] w0_code;
  logic [PC_W-1:0]  w1_pc;

  // issue side
  logic [1:0]       pop_n;
  logic             valid_q, valid_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic             comp_q, comp_d;
  logic             oexv_q, oexv_d;
  logic [EXC_W-1:0] ocode_q, ocode_d;

  // backpressure from the registered occupancy only
  assign o_stall = (CNT_W'(Q_DEPTH) - count_q) < CNT_W'(2);
  assign push_en = i_valid & ~o_stall & ~i_flush;
  assign nxt     = head_q + PTR_W'(1);
  assign w1_pc   = i_pc + PC_W'(2);

  // decode how many entries the incoming fetch word contributes
  always_comb begin
    push_n  = 2'd0;
    w0_half = i_data0;
    w0_exv  = 1'b0;
    w0_code = '0;
    if (push_en) begin
      if (i_except_valid) begin
        push_n  = 2'd1;
        w0_half = '0;
        w0_exv  = 1'b1;
        w0_code = i_except_code;
      end else if (i_pc[1]) begin
        push_n = 2'd1;
        if (RVC_EN) begin
          w0_half = i_data1;
        end else begin
          w0_half = '0;
          w0_exv  = 1'b1;
          w0_code = EXC_W'(EXC_MISALIGN);
        end
      end else begin
        push_n = 2'd2;
      end
    end
  end

  // select the next aligned instruction from entries present this cycle
  always_comb begin
    pop_n   = 2'd0;
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    comp_d  = comp_q;
    oexv_d  = oexv_q;
    ocode_d = ocode_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (!i_stall) begin
      valid_d = 1'b0;
      if (count_q != '0) begin
        if (exv_q[head_q]) begin
          valid_d = 1'b1;
          pc_d    = epc_q[head_q];
          instr_d = '0;
          comp_d  = 1'b0;
          oexv_d  = 1'b1;
          ocode_d = ecode_q[head_q];
          pop_n   = 2'd1;
        end else if (RVC_EN && (half_q[head_q][1:0] != 2'b11)) begin
          valid_d = 1'b1;
          pc_d    = epc_q[head_q];
          instr_d = {16'h0000, half_q[head_q]};
          comp_d  = 1'b1;
          oexv_d  = 1'b0;
          ocode_d = '0;
          pop_n   = 2'd1;
        end else if (count_q >= CNT_W'(2)) begin
          // a lone low half waits here until its upper half arrives
          valid_d = 1'b1;
          pc_d    = epc_q[head_q];
          comp_d  = 1'b0;
          pop_n   = 2'd2;
          if (exv_q[nxt]) begin
            instr_d = '0;
            oexv_d  = 1'b1;
            ocode_d = ecode_q[nxt];
          end else begin
            instr_d = {half_q[nxt], half_q[head_q]};
            oexv_d  = 1'b0;
            ocode_d = '0;
          end
        end
      end
    end
  end

  // queue pointer and occupancy update; flush empties the queue
  always_comb begin
    head_d  = head_q + PTR_W'(pop_n);
    tail_d  = tail_q + PTR_W'(push_n);
    count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // queue state and entry storage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < Q_DEPTH; i++) begin
        half_q[i]  <= '0;
        epc_q[i]   <= '0;
        exv_q[i]   <= 1'b0;
        ecode_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_n != 2'd0) begin
        half_q[tail_q]  <= w0_half;
        epc_q[tail_q]   <= i_pc;
        exv_q[tail_q]   <= w0_exv;
        ecode_q[tail_q] <= w0_code;
      end
      if (push_n == 2'd2) begin
        half_q[tail_q + PTR_W'(1)]  <= i_data1;
        epc_q[tail_q + PTR_W'(1)]   <= w1_pc;
        exv_q[tail_q + PTR_W'(1)]   <= 1'b0;
        ecode_q[tail_q + PTR_W'(1)] <= '0;
      end
    end
  end

  // registered instruction outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      comp_q  <= 1'b0;
      oexv_q  <= 1'b0;
      ocode_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      comp_q  <= comp_d;
      oexv_q  <= oexv_d;
      ocode_q <= ocode_d;
    end
  end

  assign o_valid        = valid_q;
  assign o_pc           = pc_q;
  assign o_instr        = instr_q;
  assign o_compressed   = comp_q;
  assign o_except_valid = oexv_q;
  assign o_except_code  = ocode_q;

endmodule

// File: tb/tb_instr_align.sv
// Self-checking bench for instr_align: queue-based reference model plus
// directed literal checks, then randomized fetch traffic.
module tb_instr_align;

  localparam int QD = 4;
  localparam logic [3:0] MISALIGN = 4'd0;

  bit          clk = 1'b0;
  logic        rst_n;
  logic        flush, stall, valid, exv;
  logic [31:0] pc;
  logic [15:0] d0, d1;
  logic [3:0]  ecode;
  logic        o_stall, o_valid, o_compressed, o_except_valid;
  logic [31:0] o_pc, o_instr;
  logic [3:0]  o_except_code;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  instr_align dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_stall(stall),
    .i_valid(valid), .i_pc(pc), .i_data0(d0), .i_data1(d1),
    .i_except_valid(exv), .i_except_code(ecode),
    .o_stall(o_stall), .o_valid(o_valid), .o_pc(o_pc), .o_instr(o_instr),
    .o_compressed(o_compressed), .o_except_valid(o_except_valid),
    .o_except_code(o_except_code)
  );

  // reference model: queue of halfwords plus the expected output registers
  typedef struct {
    logic [15:0] half;
    logic [31:0] pc;
    bit          exv;
    logic [3:0]  code;
  } ent_t;

  ent_t        mq[$];
  bit          m_valid = 1'b0, m_c = 1'b0, m_ev = 1'b0;
  logic [31:0] m_pc = '0, m_instr = '0;
  logic [3:0]  m_code = '0;

  function automatic bit is_rvc(input logic [15:0] h);
`ifdef INSTR_ALIGN_RVC_EN
    return h[1:0] != 2'b11;
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_emit(input logic [31:0] p, input logic [31:0] ins, input bit c,
                        input bit e, input logic [3:0] cd);
    m_valid = 1'b1; m_pc = p; m_instr = ins; m_c = c; m_ev = e; m_code = cd;
  endtask

  task automatic model_step();
    int   cnt;
    bit   full;
    ent_t h, e1, n;
    cnt  = mq.size();
    full = (QD - cnt) < 2;
    if (flush) begin
      mq.delete();
      m_valid = 1'b0;
      return;
    end
    if (!stall) begin
      m_valid = 1'b0;
      if (cnt > 0) begin
        h = mq[0];
        if (h.exv) begin
          m_emit(h.pc, 32'h0, 1'b0, 1'b1, h.code);
          void'(mq.pop_front());
        end else if (is_rvc(h.half)) begin
          m_emit(h.pc, {16'h0, h.half}, 1'b1, 1'b0, 4'h0);
          void'(mq.pop_front());
        end else if (cnt >= 2) begin
          e1 = mq[1];
          if (e1.exv) m_emit(h.pc, 32'h0, 1'b0, 1'b1, e1.code);
          else        m_emit(h.pc, {e1.half, h.half}, 1'b0, 1'b0, 4'h0);
          void'(mq.pop_front());
          void'(mq.pop_front());
        end
      end
    end
    if (valid && !full) begin
      if (exv) begin
        n = '{16'h0, pc, 1'b1, ecode}; mq.push_back(n);
      end else if (pc[1]) begin
`ifdef INSTR_ALIGN_RVC_EN
        n = '{d1, pc, 1'b0, 4'h0}; mq.push_back(n);
`else
        n = '{16'h0, pc, 1'b1, MISALIGN}; mq.push_back(n);
`endif
      end else begin
        n = '{d0, pc, 1'b0, 4'h0};        mq.push_back(n);
        n = '{d1, pc + 32'd2, 1'b0, 4'h0}; mq.push_back(n);
      end
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    bit ms;
    if (chk_en && rst_n) begin
      ms = (QD - mq.size()) < 2;
      n_cmp++;
      if (o_stall !== ms || o_valid !== m_valid ||
          (m_valid && (o_pc !== m_pc || o_instr !== m_instr || o_compressed !== m_c ||
                       o_except_valid !== m_ev || (m_ev && o_except_code !== m_code)))) begin
        n_bad++;
        $display("FAIL cycle@%0t: got stall=%0b v=%0b pc=%h instr=%h c=%0b ev=%0b code=%0d, want stall=%0b v=%0b pc=%h instr=%h c=%0b ev=%0b code=%0d",
                 $time, o_stall, o_valid, o_pc, o_instr, o_compressed, o_except_valid, o_except_code,
                 ms, m_valid, m_pc, m_instr, m_c, m_ev, m_code);
      end
    end
  end

  task automatic tick(input bit v, input logic [31:0] p, input logic [15:0] a, input logic [15:0] b,
                      input bit e, input logic [3:0] cd, input bit st, input bit fl);
    valid = v; pc = p; d0 = a; d1 = b; exv = e; ecode = cd; stall = st; flush = fl;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input bit st = 1'b0);
    tick(1'b0, 32'h0, 16'h0, 16'h0, 1'b0, 4'h0, st, 1'b0);
  endtask

  task automatic chk(input string nm, input bit ev_v, input logic [31:0] e_pc, input logic [31:0] e_ins,
                     input bit e_c, input bit e_ev, input logic [3:0] e_code);
    n_cmp++;
    if (o_valid !== ev_v ||
        (ev_v && (o_pc !== e_pc || o_instr !== e_ins || o_compressed !== e_c ||
                  o_except_valid !== e_ev || (e_ev && o_except_code !== e_code)))) begin
      n_bad++;
      $display("FAIL %s: got v=%0b pc=%h instr=%h c=%0b ev=%0b code=%0d, want v=%0b pc=%h instr=%h c=%0b ev=%0b code=%0d",
               nm, o_valid, o_pc, o_instr, o_compressed, o_except_valid, o_except_code,
               ev_v, e_pc, e_ins, e_c, e_ev, e_code);
    end
  endtask

  task automatic chk_stall(input string nm, input bit e);
    n_cmp++;
    if (o_stall !== e) begin
      n_bad++;
      $display("FAIL %s: got o_stall=%0b want %0b", nm, o_stall, e);
    end
  endtask

  task automatic chk_reset(input string nm);
    n_cmp++;
    if (o_valid !== 1'b0 || o_pc !== 32'h0 || o_instr !== 32'h0 || o_compressed !== 1'b0 ||
        o_except_valid !== 1'b0 || o_except_code !== 4'h0 || o_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got v=%0b pc=%h instr=%h c=%0b ev=%0b code=%0d stall=%0b, want all zero",
               nm, o_valid, o_pc, o_instr, o_compressed, o_except_valid, o_except_code, o_stall);
    end
  endtask

  // three entries queued with an instruction on the outputs
  task automatic fill_three();
    tick(1'b1, 32'h500, 16'h0513, 16'h0010, 1'b0, 4'h0, 1'b0, 1'b0);
    tick(1'b1, 32'h50a, 16'hbeef, 16'h0001, 1'b0, 4'h0, 1'b0, 1'b0);
    tick(1'b1, 32'h50c, 16'h4501, 16'h4581, 1'b0, 4'h0, 1'b1, 1'b0);
  endtask

  function automatic logic [15:0] rand_half();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(1) == 0) h[1:0] = 2'b11;
    return h;
  endfunction

  initial begin
    logic [31:0] fpc;
    bit          rv, rst_, rfl, rev, acc;
    rst_n = 1'b0;
    valid = 1'b0; pc = '0; d0 = '0; d1 = '0; exv = 1'b0; ecode = '0; stall = 1'b0; flush = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk_reset("reset");
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // A: two halves of one aligned word
    tick(1'b1, 32'h100, 16'h4501, 16'h4581, 1'b0, 4'h0, 1'b0, 1'b0);
    idle();
`ifdef INSTR_ALIGN_RVC_EN
    chk("A0", 1'b1, 32'h100, 32'h0000_4501, 1'b1, 1'b0, 4'h0);
    idle();
    chk("A1", 1'b1, 32'h102, 32'h0000_4581, 1'b1, 1'b0, 4'h0);
`else
    chk("A0", 1'b1, 32'h100, 32'h4581_4501, 1'b0, 1'b0, 4'h0);
    idle();
    chk("A1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
`endif
    idle();
    chk("A2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);

    // B: 32-bit instruction spanning a fetch-word boundary
    tick(1'b1, 32'h200, 16'h0001, 16'h0513, 1'b0, 4'h0, 1'b0, 1'b0);
    tick(1'b1, 32'h204, 16'h0010, 16'h8082, 1'b0, 4'h0, 1'b0, 1'b0);
`ifdef INSTR_ALIGN_RVC_EN
    chk("B0", 1'b1, 32'h200, 32'h0000_0001, 1'b1, 1'b0, 4'h0);
    idle();
    chk("B1", 1'b1, 32'h202, 32'h0010_0513, 1'b0, 1'b0, 4'h0);
    idle();
    chk("B2", 1'b1, 32'h206, 32'h0000_8082, 1'b1, 1'b0, 4'h0);
`else
    chk("B0", 1'b1, 32'h200, 32'h0513_0001, 1'b0, 1'b0, 4'h0);
    idle();
    chk("B1", 1'b1, 32'h204, 32'h8082_0010, 1'b0, 1'b0, 4'h0);
    idle();
    chk("B2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
`endif
    idle();

    // C: redirect to pc[1]=1
    tick(1'b1, 32'h302, 16'hdead, 16'h0093, 1'b0, 4'h0, 1'b0, 1'b0);
    tick(1'b1, 32'h304, 16'h0010, 16'h4501, 1'b0, 4'h0, 1'b0, 1'b0);
`ifdef INSTR_ALIGN_RVC_EN
    chk("C0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
    idle();
    chk("C1", 1'b1, 32'h302, 32'h0010_0093, 1'b0, 1'b0, 4'h0);
    idle();
    chk("C2", 1'b1, 32'h306, 32'h0000_4501, 1'b1, 1'b0, 4'h0);
`else
    chk("C0", 1'b1, 32'h302, 32'h0, 1'b0, 1'b1, MISALIGN);
    idle();
    chk("C1", 1'b1, 32'h304, 32'h4501_0010, 1'b0, 1'b0, 4'h0);
    idle();
    chk("C2", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
`endif
    idle();

    // D: fetch exception following a low half
`ifdef INSTR_ALIGN_RVC_EN
    tick(1'b1, 32'h402, 16'h0000, 16'h0513, 1'b0, 4'h0, 1'b0, 1'b0);
    tick(1'b1, 32'h404, 16'h0000, 16'h0000, 1'b1, 4'd12, 1'b0, 1'b0);
    chk("D0", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
    idle();
    chk("D1", 1'b1, 32'h402, 32'h0, 1'b0, 1'b1, 4'd12);
`else
    tick(1'b1, 32'h400, 16'h0513, 16'h0001, 1'b0, 4'h0, 1'b0, 1'b0);
    tick(1'b1, 32'h404, 16'h0000, 16'h0000, 1'b1, 4'd12, 1'b0, 1'b0);
    chk("D0", 1'b1, 32'h400, 32'h0001_0513, 1'b0, 1'b0, 4'h0);
    idle();
    chk("D1", 1'b1, 32'h404, 32'h0, 1'b0, 1'b1, 4'd12);
`endif
    idle();

    // F: flush with three entries queued and an output valid, stall also high
    fill_three();
    chk("F0", 1'b1, 32'h500, 32'h0010_0513, 1'b0, 1'b0, 4'h0);
    chk_stall("F0_stall", 1'b1);
    tick(1'b1, 32'h510, 16'h4501, 16'h4581, 1'b0, 4'h0, 1'b1, 1'b1);
    chk("F1", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
    chk_stall("F1_stall", 1'b0);

    // E: downstream stall with fetch valid every cycle
    tick(1'b1, 32'h600, 16'h0513, 16'h0010, 1'b0, 4'h0, 1'b0, 1'b0);
    idle();
    chk("E0", 1'b1, 32'h600, 32'h0010_0513, 1'b0, 1'b0, 4'h0);
    tick(1'b1, 32'h604, 16'h4501, 16'h4581, 1'b0, 4'h0, 1'b1, 1'b0);
    chk_stall("E1_stall", 1'b0);
    tick(1'b1, 32'h608, 16'h0593, 16'h0020, 1'b0, 4'h0, 1'b1, 1'b0);
    chk_stall("E2_stall", 1'b1);
    tick(1'b1, 32'h608, 16'h0593, 16'h0020, 1'b0, 4'h0, 1'b1, 1'b0);
    chk("E3", 1'b1, 32'h600, 32'h0010_0513, 1'b0, 1'b0, 4'h0);
    repeat (6) idle();

    // R: asynchronous reset mid-stream
    fill_three();
    #2 rst_n = 1'b0;
    #1 chk_reset("R0");
    mq.delete();
    m_valid = 1'b0; m_pc = '0; m_instr = '0; m_c = 1'b0; m_ev = 1'b0; m_code = '0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    chk_stall("R1_stall", 1'b0);

    // randomized fetch traffic
    fpc = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      rv   = $urandom_range(3) != 0;
      rst_ = $urandom_range(3) == 0;
      rfl  = $urandom_range(31) == 0;
      rev  = $urandom_range(15) == 0;
      if ($urandom_range(15) == 0) fpc = $urandom & 32'hFFFF_FFFE;
`ifndef INSTR_ALIGN_RVC_EN
      if (fpc[1]) rev = 1'b0;
`endif
      acc = rv && !o_stall && !rfl;
      tick(rv, fpc, rand_half(), rand_half(), rev, 4'($urandom), rst_, rfl);
      if (acc) fpc = fpc[1] ? fpc + 32'd2 : fpc + 32'd4;
    end
    repeat (10) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_align.md
Name: instr_align

Overview:
- Instruction-align (IA) stage, directly downstream of the fetch data-read stage.
- Consumes one fetched 32-bit word per cycle, presented as two 16-bit halves with PC and exception.
- Buffers halfwords in a small queue, reassembles RVC (16-bit) and 32-bit instructions, including those spanning a fetch-word boundary.
- Emits at most one aligned instruction per cycle to decode.

Parameters:
- PC_W, 32, program counter width
- EXC_W, 4, exception code width
- Q_DEPTH, 4, halfword queue entries (power of 2, >=4)
- EXC_MISALIGN, 0, code reported for a misaligned PC when RVC is disabled

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous flush (redirect)
- i_stall  in  1  downstream stall; hold output
- i_valid  in  1  fetched word valid
- i_pc  in  PC_W  PC of the fetched word; bit 1 may be set after a redirect
- i_data0  in  16  halfword at pc&~3
- i_data1  in  16  halfword at (pc&~3)+2
- i_except_valid  in  1  fetch exception (page fault etc.)
- i_except_code  in  EXC_W  exception code
- o_stall  out  1  backpressure to fetch
- o_valid  out  1  instruction valid
- o_pc  out  PC_W  instruction PC
- o_instr  out  32  instruction; upper 16 bits are zero when compressed
- o_compressed  out  1  16-bit instruction
- o_except_valid  out  1  exception attached
- o_except_code  out  EXC_W  exception code

Behaviour:
- Reset (async, i_rst_n=0): queue empty (head=tail=count=0); o_valid, o_compressed, o_except_valid = 0; o_pc, o_instr, o_except_code = 0.
- Queue entry = {half[15:0], pc[PC_W-1:0], exc_v, exc_code}. Head/tail wrap modulo Q_DEPTH.
- o_stall = (Q_DEPTH - count) < 2, computed from registered count only.
- Push occurs when i_valid & ~o_stall & ~i_flush:
  - i_except_valid=1: push one entry; exc set; pc = i_pc; data ignored.
  - i_pc[1]=0: push data0 at pc, then data1 at pc+2 (2 entries).
  - i_pc[1]=1: push data1 only, at i_pc (data0 discarded).
- Issue occurs when ~i_stall & ~i_flush. It uses only entries present at the start of the cycle; same-cycle pushes are not visible.
  - count=0: o_valid <= 0.
  - head.exc: emit o_except_valid=1, code=head.code, o_pc=head.pc, o_instr=0; pop 1.
  - head.half[1:0] != 2'b11: emit compressed, o_instr={16'h0,half}; pop 1.
  - head.half[1:0] == 2'b11, count=1: o_valid <= 0; no pop (wait for upper half).
  - head.half[1:0] == 2'b11, count>=2, entry1.exc: emit exception with entry1 code, o_pc=head.pc; pop 2.
  - Otherwise: emit o_instr={entry1.half, head.half}, o_compressed=0, o_pc=head.pc; pop 2.
- count_next = count + pushed - popped; push and pop may occur in the same cycle.
- Latency: a fully buffered instruction appears on outputs the cycle after it reaches the head (registered output).
- i_stall=1: all outputs and the queue head hold. Pushes still proceed while space allows.
- i_flush: count/head/tail reset; o_valid <= 0; any same-cycle push or issue is dropped. Flush has priority over stall.
- A 32-bit instruction whose low half is the last entry is never emitted partially.

Optional Feature:
- Macro INSTR_ALIGN_RVC_EN.
- Defined: behaviour as above.
- Undefined:
  - Every instruction is treated as 32-bit; o_compressed is tied 0; a head with half[1:0] != 2'b11 is still consumed as the low half of a 32-bit instruction.
  - i_pc[1]=1 with i_valid pushes a single exception entry with code EXC_MISALIGN.

Test Plan:
- Reset mid-stream (queue holding 3 entries) -> all outputs 0 immediately; o_stall=0 after release.
- Word pc=0x100, data0=0x4501, data1=0x4581 -> out pc 0x100 instr 0x00004501 C=1, next cycle pc 0x102 instr 0x00004581 C=1.
- Word pc=0x200 {d0=0x0001, d1=0x0513}, then pc=0x204 {d0=0x0010, d1=0x8082} -> 0x200 C=1 0x00000001; 0x202 instr 0x00100513; 0x206 C=1 0x00008082.
- Redirect pc=0x302, data1=0x0093 with next word pc=0x304 data0=0x0010 -> pc 0x302 instr 0x00100093 C=0.
- Low half 0x0513 queued, next word i_except_valid=1 code=12 -> o_except_valid=1, code 12, pc of low half.
- i_stall held 3 cycles with i_valid every cycle -> o_stall rises at count>=3; outputs stable; no entry lost.
- i_flush with count=3 and o_valid=1 -> next cycle o_valid=0, o_stall=0.
